// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative AES-128 decryptor.
// Contents: forward and inverse S-box tables, the Rcon table, FSM state
// encodings, the round count, and key-schedule helper functions.
// Key-schedule helpers:
//   key_step_fwd : next round key from the current one (encrypt direction)
//   key_step_inv : previous round key from the current one (walks backwards)
package aes_pkg;

    localparam int         AES_ROUNDS = 10;
    localparam logic [3:0] LAST_ROUND = 4'(AES_ROUNDS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_ROUND  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Padded to 16 entries so any 4-bit round counter indexes in range.
    localparam logic [0:15][7:0] RCON = 128'h01020408102040801b36000000000000;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        return RCON[idx];
    endfunction

    // RotWord, SubWord, then Rcon into the leading byte.
    function automatic logic [31:0] key_g(input logic [31:0] w, input logic [7:0] rc);
        return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_step_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ key_g(k[31:0], rc);
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo key_step_fwd: the last three words fall out of neighbouring XORs,
    // which then yields the g() input needed to recover the first word.
    function automatic logic [127:0] key_step_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0]  ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ key_g(p3, rc);
        return {p0, p1, p2, p3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round.
// Ports:
//   state_in   : round input state (byte 0 in [127:120], column-major)
//   round_key  : key added after InvSubBytes
//   bypass_mix : high for the final round, which skips InvMixColumns
//   state_out  : round result
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         bypass_mix,
    output logic [127:0] state_out
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]   = col[31 - 8*i -: 8];
            x2     = xtime(a[i]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m9[i]  = x8 ^ a[i];
            m11[i] = x8 ^ x2 ^ a[i];
            m13[i] = x8 ^ x4 ^ a[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [31:0] col;
        for (genvar r = 0; r < 4; r++) begin : g_row
            // InvShiftRows: row r rotates right by r, so output column c
            // takes its byte from input column (c - r) mod 4.
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            assign col[31 - 8*r -: 8] = inv_sbox(state_in[127 - 8*SRC -: 8])
                                        ^ round_key[127 - 8*(4*c + r) -: 8];
        end
        assign state_out[127 - 32*c -: 32] = bypass_mix ? col : inv_mix_col(col);
    end

endmodule

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 decryptor, one round per clock.
// Flow: IDLE accepts a job, EXPAND walks the forward key schedule to the
// round-10 key, ROUND runs ten inverse rounds while stepping the key
// backwards, DONE holds the plaintext until the consumer takes it.
// Ports:
//   Clock, Reset (synchronous, active high)
//   Key, DataIn, DataInValid, DataInReady : job input handshake
//   DataOut, DataOutValid, DataOutReady   : result output handshake
// Parameter ZeroOnIdle: 1 forces DataOut to zero while DataOutValid is low.
// Macro AES_DEC_KEYCACHE_EN: keeps the last key and its round-10 key so a
// job reusing that key skips EXPAND.
module aes_128_dec_iter
    import aes_pkg::*;
#(
    parameter bit ZeroOnIdle = 1'b1
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [127:0] Key,
    input  logic [127:0] DataIn,
    input  logic         DataInValid,
    output logic         DataInReady,
    output logic [127:0] DataOut,
    output logic         DataOutValid,
    input  logic         DataOutReady
);

    logic [1:0]   fsm;
    logic [3:0]   round_cnt;
    logic [127:0] key_q, state_q;
    logic [127:0] key_next, key_prev, round_in, round_out;
    logic         last_round;
    logic         cache_hit;
    logic [127:0] cache_rk;

    assign last_round = (round_cnt == LAST_ROUND);
    assign key_next   = key_step_fwd(key_q, rcon(round_cnt));
    assign key_prev   = key_step_inv(key_q, rcon(LAST_ROUND - round_cnt));
    // The first inverse round also absorbs the initial AddRoundKey with the
    // round-10 key, which sits in key_q on entry to ROUND.
    assign round_in   = (round_cnt == 4'd0) ? (state_q ^ key_q) : state_q;

    aes_inv_round u_inv_round (
        .state_in  (round_in),
        .round_key (key_prev),
        .bypass_mix(last_round),
        .state_out (round_out)
    );

`ifdef AES_DEC_KEYCACHE_EN
    logic         cache_valid;
    logic [127:0] cache_key;

    assign cache_hit = cache_valid && (Key == cache_key);

    // NOTE: the cache entry is cleared on reset like any other register, so
    //       a stale round-10 key can never be reused after reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cache_valid <= 1'b0;
            cache_key   <= '0;
            cache_rk    <= '0;
        end else if (fsm == ST_IDLE && DataInValid && !cache_hit) begin
            // Key is remembered now but only becomes usable once its
            // round-10 key is complete.
            cache_valid <= 1'b0;
            cache_key   <= Key;
        end else if (fsm == ST_EXPAND && last_round) begin
            cache_valid <= 1'b1;
            cache_rk    <= key_next;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_rk  = '0;
`endif

    // NOTE: all state uses non-blocking assignments so every register in
    //       this block samples pre-edge values, independent of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fsm       <= ST_IDLE;
            round_cnt <= '0;
            key_q     <= '0;
            state_q   <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (DataInValid) begin
                        state_q   <= DataIn;
                        round_cnt <= '0;
                        if (cache_hit) begin
                            key_q <= cache_rk;
                            fsm   <= ST_ROUND;
                        end else begin
                            key_q <= Key;
                            fsm   <= ST_EXPAND;
                        end
                    end
                end
                ST_EXPAND: begin
                    key_q <= key_next;
                    if (last_round) begin
                        round_cnt <= '0;
                        fsm       <= ST_ROUND;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                ST_ROUND: begin
                    key_q   <= key_prev;
                    state_q <= round_out;
                    if (last_round) begin
                        round_cnt <= '0;
                        fsm       <= ST_DONE;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (DataOutReady) begin
                        fsm <= ST_IDLE;
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    assign DataInReady  = (fsm == ST_IDLE);
    assign DataOutValid = (fsm == ST_DONE);
    assign DataOut      = (ZeroOnIdle && !DataOutValid) ? '0 : state_q;

endmodule

// File: doc/aes_128_dec_iter.md
AES_128_DEC_ITER -- requirements
Module: aes_128_dec_iter

Interface
REQ-001 SHALL have parameter ZeroOnIdle, 1, DataOut forced to 128'h0 whenever DataOutValid is low.
REQ-002 SHALL have port Clock  input  1  single clock for all logic.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Key  input  128  cipher key; byte 0 in [127:120]; sampled on input handshake.
REQ-005 SHALL have port DataIn  input  128  ciphertext block; byte 0 in [127:120]; sampled on input handshake.
REQ-006 SHALL have port DataInValid  input  1  DataIn/Key valid.
REQ-007 SHALL have port DataInReady  output  1  block can accept a new job.
REQ-008 SHALL have port DataOut  output  128  recovered plaintext, same byte order.
REQ-009 SHALL have port DataOutValid  output  1  DataOut valid.
REQ-010 SHALL have port DataOutReady  input  1  consumer accepts DataOut.

Function
REQ-011 SHALL implement FIPS-197 AES-128 decryption, inverse of the team's aes_128 encryptor, one round per cycle.
REQ-012 SHALL use FSM states IDLE, EXPAND, ROUND, DONE.
REQ-013 SHALL assert DataInReady only in IDLE; handshake = DataInValid & DataInReady.
REQ-014 IDLE: on handshake, register Key and DataIn and go to EXPAND; otherwise stay.
REQ-015 EXPAND: run forward key schedule one round key per cycle for exactly 10 cycles, ending with round-10 key held in a register, then go to ROUND.
REQ-016 ROUND first cycle: state = DataIn xor round-10 key combined with round 10 inverse step; 10 ROUND cycles total; rounds 9..1 include InvMixColumns, final round (key 0) omits it.
REQ-017 ROUND: round key SHALL be stepped backwards each cycle via inverse key schedule (w[i-4] = w[i] xor g(w[i-1])), Rcon descending 0x36..0x01; no 11-key storage.
REQ-018 After 10th ROUND cycle go to DONE; DataOutValid SHALL be high in DONE only.
REQ-019 Latency without cache hit: handshake in cycle 0 -> DataOutValid high in cycle 21.
REQ-020 DONE: hold DataOut/DataOutValid stable until DataOutReady; on DataOutValid & DataOutReady go to IDLE next cycle.
REQ-021 DataInValid asserted outside IDLE SHALL be ignored (no capture, no state change).
REQ-022 ZeroOnIdle=0: DataOut SHALL show internal state register content at all times (don't-care outside DONE).
REQ-023 Round counter SHALL be 4 bits, wrap not permitted; values 10..15 unreachable.

Reset
REQ-024 Reset SHALL force state IDLE, DataInReady=1 on next cycle, DataOutValid=0, DataOut=0, round counter=0, all key/state registers cleared.
REQ-025 Reset mid-EXPAND/ROUND/DONE SHALL abandon job; no DataOutValid for it.
REQ-026 With cache enabled, reset SHALL invalidate the cache entry.

Configuration
REQ-027 Macro AES_DEC_KEYCACHE_EN, when defined, SHALL keep last Key and its round-10 key plus a valid bit.
REQ-028 With AES_DEC_KEYCACHE_EN: handshake with Key equal to cached valid key SHALL skip EXPAND (IDLE->ROUND), DataOutValid in cycle 11; miss behaves as REQ-019 and updates cache at EXPAND end.
REQ-029 Without AES_DEC_KEYCACHE_EN: no cache registers; every job takes EXPAND; latency always 21.

Structure
REQ-030 Shared package aes_pkg SHALL hold forward S-box and inverse S-box tables, Rcon table, state encoding constants, AES_ROUNDS=10.
REQ-031 One sub-module aes_inv_round SHALL be combinational: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns bypass input for final round.

Verification
REQ-032 Key 000102030405060708090a0b0c0d0e0f, DataIn 69c4e0d86a7b0430d8cdb78070b4c55a -> DataOut 00112233445566778899aabbccddeeff, valid cycle 21.
REQ-033 Key 2b7e151628aed2a6abf7158809cf4f3c, DataIn 3925841d02dc09fbdc118597196a0b32 -> DataOut 3243f6a8885a308d313198a2e0370734.
REQ-034 DataOutReady held low 50 cycles in DONE -> DataOut stable, DataInReady low, extra DataInValid ignored; ready high -> IDLE next cycle.
REQ-035 Reset pulse in ROUND cycle 5 -> DataOutValid never asserts, DataOut=0, DataInReady=1 cycle after reset; next job decrypts correctly.
REQ-036 AES_DEC_KEYCACHE_EN: REQ-032 twice back-to-back -> second valid in cycle 11; then REQ-033 key -> cycle 21; after reset same key -> cycle 21.
REQ-037 Random 1000 keys/blocks against reference model with random DataOutReady stalls -> all outputs match, none lost or duplicated.
